// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a small pointer-addressed bank of 8-bit registers.
// SCL/SDA are oversampled in the fabric clock domain; SDA is driven open-drain.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         NUM_REGS    = 4,
    parameter int         CLK_DIV_MIN = 10
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESETN,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    output logic [7:0] oLed,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int PTR_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_PTR       = 3'd3,
        ST_WDATA     = 3'd4,
        ST_RDATA     = 3'd5,
        ST_WAIT_STOP = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    logic             scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]       rx_byte_s;
    logic [PTR_W-1:0] ptr_inc_s;

    // Two-flop synchroniser on both bus lines plus one history stage for edge detection
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= I2C_SCL;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= I2C_SDA;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise_s = scl_sync_q & ~scl_prev_q;
    assign scl_fall_s = ~scl_sync_q & scl_prev_q;
    assign start_s    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_s     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    assign rx_byte_s  = {shift_q[6:0], sda_sync_q};
    assign ptr_inc_s  = ptr_q + PTR_W'(1);

    // Protocol FSM: bit_cnt counts SCL rises, 8 marks the ACK slot of the current byte
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (start_s) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (scl_rise_s) begin
            if (bit_cnt_q < 4'd8) begin
                shift_d   = rx_byte_s;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    case (state_q)
                        ST_ADDR: begin
                            if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                        ST_PTR: begin
                            ptr_d = rx_byte_s[PTR_W-1:0];
                        end
                        ST_WDATA: begin
                            regs_d[ptr_q] = rx_byte_s;
                            wr_pulse_d    = 1'b1;
                            wr_addr_d     = 8'(ptr_q);
                            wr_data_d     = rx_byte_s;
                            ptr_d         = ptr_inc_s;
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end else begin
                bit_cnt_d = 4'd0;
                case (state_q)
                    ST_ADDR_ACK: begin
                        // LSB of the address byte is R/W
                        if (shift_q[0]) begin
                            shift_d = regs_q[ptr_q];
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_PTR;
                        end
                    end
                    ST_PTR: begin
                        state_d = ST_WDATA;
                    end
                    ST_RDATA: begin
                        ptr_d = ptr_inc_s;
                        if (!sda_sync_q) begin
                            shift_d = regs_q[ptr_inc_s];
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end else if (scl_fall_s) begin
            case (state_q)
                ST_ADDR_ACK, ST_PTR, ST_WDATA: sda_oe_d = (bit_cnt_q == 4'd8);
                ST_RDATA:                      sda_oe_d = (bit_cnt_q != 4'd8) && !shift_q[7];
                default:                       sda_oe_d = 1'b0;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= '0;
            regs_q     <= '{default: 8'd0};
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign I2C_SDA  = sda_oe_q ? 1'b0 : 1'bz;
    assign oLed     = regs_q[0];
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master drives the bus
// and checks ACKs, read data, write strobes and reset behaviour.
module tb_i2c_slave_regfile;

    localparam int HALF = 16;
    localparam int Q    = 8;

    logic       clk;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda_oe;
    wire        sda_w;
    logic [7:0] oled;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int         tests;
    int         fails;
    int         wr_cnt;
    logic [7:0] last_addr;
    logic [7:0] last_data;
    logic       dut_low;
    logic       busy_seen;

    assign sda_w = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h50),
        .NUM_REGS   (4),
        .CLK_DIV_MIN(10)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .I2C_SCL      (m_scl),
        .I2C_SDA      (sda_w),
        .oLed         (oled),
        .wr_pulse     (wr_pulse),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: write strobes, target pulling SDA low, busy activity
    always @(negedge clk) begin
        if (wr_pulse) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (!m_sda_oe && sda_w === 1'b0) dut_low <= 1'b1;
        if (busy) busy_seen <= 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One SCL period starting and ending with SCL low; drive=1 releases SDA
    task automatic bit_xfer(input logic drive, output logic sampled);
        tick(Q);
        m_sda_oe = ~drive;
        tick(HALF - Q);
        m_scl = 1'b1;
        tick(HALF / 2);
        sampled = sda_w;
        tick(HALF - HALF / 2);
        m_scl = 1'b0;
    endtask

    task automatic start_cond();
        tick(Q);
        m_sda_oe = 1'b0;
        tick(HALF - Q);
        m_scl = 1'b1;
        tick(HALF);
        m_sda_oe = 1'b1;
        tick(HALF);
        m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(Q);
        m_sda_oe = 1'b1;
        tick(HALF - Q);
        m_scl = 1'b1;
        tick(HALF);
        m_sda_oe = 1'b0;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack_m, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(~ack_m, s);
    endtask

    logic       ack;
    logic       s;
    logic [7:0] rd;
    int         wr_snap;

    initial begin
        tests     = 0;
        fails     = 0;
        wr_cnt    = 0;
        last_addr = 8'h00;
        last_data = 8'h00;
        dut_low   = 1'b0;
        busy_seen = 1'b0;
        rst_n     = 1'b0;
        m_scl     = 1'b1;
        m_sda_oe  = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);

        check("rst_oled",     oled,              8'h00);
        check("rst_busy",     {7'd0, busy},      8'h00);
        check("rst_wr_pulse", {7'd0, wr_pulse},  8'h00);
        check("rst_wr_addr",  wr_addr,           8'h00);
        check("rst_wr_data",  wr_data,           8'h00);
        check("rst_sda",      {7'd0, sda_w},     8'h01);

        // 1: simple write of A5 to reg0
        start_cond();
        send_byte(8'hA0, ack);
        check("t1_addr_ack", {7'd0, ack},  8'h01);
        check("t1_busy",     {7'd0, busy}, 8'h01);
        send_byte(8'h00, ack);
        check("t1_ptr_ack",  {7'd0, ack},  8'h01);
        send_byte(8'hA5, ack);
        check("t1_data_ack", {7'd0, ack},  8'h01);
        stop_cond();
        check("t1_wr_cnt",   8'(wr_cnt),   8'h01);
        check("t1_wr_addr",  last_addr,    8'h00);
        check("t1_wr_data",  last_data,    8'hA5);
        check("t1_oled",     oled,         8'hA5);
        check("t1_busy_end", {7'd0, busy}, 8'h00);

        // 2: write 11,22 at ptr 1, then pointer-set + repeated START read
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h01, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack);
        check("t2_data_ack", {7'd0, ack}, 8'h01);
        stop_cond();
        check("t2_wr_cnt",   8'(wr_cnt),  8'h03);
        check("t2_wr_addr",  last_addr,   8'h02);
        check("t2_wr_data",  last_data,   8'h22);
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h01, ack);
        start_cond();
        send_byte(8'hA1, ack);
        check("t2_rd_addr_ack", {7'd0, ack}, 8'h01);
        read_byte(1'b1, rd);
        check("t2_rd0", rd, 8'h11);
        read_byte(1'b0, rd);
        check("t2_rd1", rd, 8'h22);
        stop_cond();
        check("t2_busy_end", {7'd0, busy}, 8'h00);
        // ptr should now be 3: reg3 is still zero, unlike reg0..2
        start_cond();
        send_byte(8'hA1, ack);
        read_byte(1'b0, rd);
        stop_cond();
        check("t2_ptr3", rd, 8'h00);

        // 3: wrong address is ignored entirely
        wr_snap   = wr_cnt;
        dut_low   = 1'b0;
        busy_seen = 1'b0;
        start_cond();
        send_byte(8'hA2, ack);
        check("t3_addr_nack", {7'd0, ack}, 8'h00);
        send_byte(8'h00, ack);
        check("t3_data_nack", {7'd0, ack}, 8'h00);
        stop_cond();
        check("t3_no_drive",  {7'd0, dut_low},   8'h00);
        check("t3_no_busy",   {7'd0, busy_seen}, 8'h00);
        check("t3_no_write",  8'(wr_cnt - wr_snap), 8'h00);
        check("t3_oled",      oled, 8'hA5);

        // 4: pointer wrap on write
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        send_byte(8'h33, ack);
        send_byte(8'h44, ack);
        stop_cond();
        check("t4_wr_cnt",  8'(wr_cnt), 8'h05);
        check("t4_wr_addr", last_addr,  8'h00);
        check("t4_wr_data", last_data,  8'h44);
        check("t4_oled",    oled,       8'h44);
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        start_cond();
        send_byte(8'hA1, ack);
        read_byte(1'b0, rd);
        stop_cond();
        check("t4_reg3", rd, 8'h33);

        // 5: STOP mid-byte discards the partial write
        wr_snap = wr_cnt;
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h02, ack);
        bit_xfer(1'b1, s);
        bit_xfer(1'b0, s);
        bit_xfer(1'b1, s);
        bit_xfer(1'b0, s);
        stop_cond();
        check("t5_no_write", 8'(wr_cnt - wr_snap), 8'h00);
        check("t5_busy",     {7'd0, busy}, 8'h00);
        start_cond();
        send_byte(8'hA0, ack);
        check("t5_next_ack", {7'd0, ack}, 8'h01);
        send_byte(8'h02, ack);
        send_byte(8'h5A, ack);
        stop_cond();
        check("t5_wr_cnt",  8'(wr_cnt - wr_snap), 8'h01);
        check("t5_wr_addr", last_addr, 8'h02);
        check("t5_wr_data", last_data, 8'h5A);
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h02, ack);
        start_cond();
        send_byte(8'hA1, ack);
        read_byte(1'b0, rd);
        stop_cond();
        check("t5_reg2", rd, 8'h5A);

        // 6: async reset while the target drives bit 3 of reg0 (0x44)
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h00, ack);
        start_cond();
        send_byte(8'hA1, ack);
        bit_xfer(1'b1, s);
        check("t6_bit0", {7'd0, s}, 8'h00);
        bit_xfer(1'b1, s);
        check("t6_bit1", {7'd0, s}, 8'h01);
        bit_xfer(1'b1, s);
        tick(Q);
        check("t6_drive_low", {7'd0, sda_w}, 8'h00);
        rst_n = 1'b0;
        #1;
        check("t6_sda_rel", {7'd0, sda_w}, 8'h01);
        check("t6_oled",    oled,          8'h00);
        check("t6_busy",    {7'd0, busy},  8'h00);
        check("t6_wr_addr", wr_addr,       8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        m_scl = 1'b1;
        tick(HALF);
        start_cond();
        send_byte(8'hA0, ack);
        check("t6_post_ack", {7'd0, ack}, 8'h01);
        send_byte(8'h00, ack);
        start_cond();
        send_byte(8'hA1, ack);
        read_byte(1'b1, rd);
        check("t6_reg0", rd, 8'h00);
        read_byte(1'b1, rd);
        check("t6_reg1", rd, 8'h00);
        read_byte(1'b1, rd);
        check("t6_reg2", rd, 8'h00);
        read_byte(1'b0, rd);
        check("t6_reg3", rd, 8'h00);
        stop_cond();
        check("t6_busy_end", {7'd0, busy}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
